// File: rtl/multi_way_signal_ctrl_pkg.sv
// Shared lamp/phase encodings and FSM state type
// for the multi-approach signal controller.
package sig_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_GRN = 3'b010;
  localparam logic [2:0] LAMP_YEL = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] PH_ALLRED = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_FLASH  = 2'b11;

  typedef enum logic [1:0] {
    ST_ALLRED,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } state_t;

  function automatic int max_of(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/multi_way_signal_ctrl_if.sv
// Demand/maintenance inputs and lamp outputs
// of the signal controller.
interface multi_way_signal_ctrl_if #(
  parameter int NUM_DIR = 4
);

  localparam int DIR_W = $clog2(NUM_DIR);

  logic [NUM_DIR-1:0]   req;
  logic                 flash;
  logic [3*NUM_DIR-1:0] light;
  logic [DIR_W-1:0]     active_dir;
  logic [1:0]           phase;

  modport master (
    output req,
    output flash,
    input  light,
    input  active_dir,
    input  phase
  );

  modport slave (
    input  req,
    input  flash,
    output light,
    output active_dir,
    output phase
  );

endinterface

// File: rtl/multi_way_signal_ctrl_phase_timer.sv
// Loadable down-counter; holds at zero and flags it.
// Shared by phase timing and flash half-periods.
module phase_timer #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= CNT_W'(RST_VAL);
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/multi_way_signal_ctrl.sv
// Moore signal controller: demand-skipping rotation
// of green/yellow/all-red plus flashing-yellow mode.
module multi_way_signal_ctrl
  import sig_pkg::*;
#(
  parameter int NUM_DIR       = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int FLASH_CYCLES  = 4
) (
  input logic                    clock,
  input logic                    reset,
  multi_way_signal_ctrl_if.slave bus
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam int MAXD  = max_of(GREEN_CYCLES,
    YELLOW_CYCLES, ALLRED_CYCLES, FLASH_CYCLES);
  localparam int CNT_W = $clog2(MAXD) + 1;

  localparam logic [CNT_W-1:0] T_GRN =
    CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_YEL =
    CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_ALR =
    CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_FLS =
    CNT_W'(FLASH_CYCLES - 1);
  localparam logic [DIR_W-1:0] LAST =
    DIR_W'(NUM_DIR - 1);

  state_t             state, state_n;
  logic [DIR_W-1:0]   dir, dir_n;
  logic               fon, fon_n;
  logic               ld;
  logic [CNT_W-1:0]   ld_val;
  logic               tz;
  logic [3*NUM_DIR-1:0] lamps;

  // Cyclic search from cur+1; modulo keeps odd NUM_DIR safe.
  function automatic logic [DIR_W-1:0] next_dir(
    input logic [DIR_W-1:0]   cur,
    input logic [NUM_DIR-1:0] r
  );
    int   idx;
    logic hit;
    next_dir = DIR_W'((int'(cur) + 1) % NUM_DIR);
    hit = 1'b0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = (int'(cur) + k) % NUM_DIR;
      if (!hit && r[idx]) begin
        next_dir = DIR_W'(idx);
        hit = 1'b1;
      end
    end
  endfunction

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_CYCLES - 1)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .load (ld),
    .value(ld_val),
    .zero (tz)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ALLRED;
      dir   <= LAST;
      fon   <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      fon   <= fon_n;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    fon_n   = fon;
    ld      = 1'b0;
    ld_val  = '0;
    if (bus.flash) begin
      if (state != ST_FLASH) begin
        state_n = ST_FLASH;
        fon_n   = 1'b1;
        ld      = 1'b1;
        ld_val  = T_FLS;
      end else if (tz) begin
        fon_n  = ~fon;
        ld     = 1'b1;
        ld_val = T_FLS;
      end
    end else begin
      unique case (state)
        ST_FLASH: begin
          state_n = ST_ALLRED;
          dir_n   = LAST;
          ld      = 1'b1;
          ld_val  = T_ALR;
        end
        ST_ALLRED: if (tz) begin
          state_n = ST_GREEN;
          dir_n   = next_dir(dir, bus.req);
          ld      = 1'b1;
          ld_val  = T_GRN;
        end
        ST_GREEN: if (tz) begin
          state_n = ST_YELLOW;
          ld      = 1'b1;
          ld_val  = T_YEL;
        end
        ST_YELLOW: if (tz) begin
          state_n = ST_ALLRED;
          ld      = 1'b1;
          ld_val  = T_ALR;
        end
      endcase
    end
  end

  always_comb begin
    lamps     = '0;
    bus.phase = PH_ALLRED;
    for (int d = 0; d < NUM_DIR; d++) begin
      lamps[3*d +: 3] = LAMP_RED;
    end
    unique case (state)
      ST_ALLRED: bus.phase = PH_ALLRED;
      ST_GREEN: begin
        bus.phase = PH_GREEN;
        lamps[3*int'(dir) +: 3] = LAMP_GRN;
      end
      ST_YELLOW: begin
        bus.phase = PH_YELLOW;
        lamps[3*int'(dir) +: 3] = LAMP_YEL;
      end
      ST_FLASH: begin
        bus.phase = PH_FLASH;
        for (int d = 0; d < NUM_DIR; d++) begin
          lamps[3*d +: 3] = fon ? LAMP_YEL : LAMP_OFF;
        end
      end
    endcase
  end

  assign bus.light      = lamps;
  assign bus.active_dir = dir;

endmodule

// File: doc/multi_way_signal_ctrl.md
Name: multi_way_signal_ctrl

Overview:
- Parametrised Moore-machine signal controller for an intersection of NUM_DIR approaches.
- Per-phase programmable durations, demand-based skipping of idle approaches, and a flashing-yellow maintenance mode.
- Generalises the fixed three-state single-lamp cycler. Drives one RGY lamp group per approach; sits under the top-level intersection wrapper.

Parameters:
- NUM_DIR, 4, number of approaches (>=2).
- GREEN_CYCLES, 8, clocks each green phase lasts (>=1).
- YELLOW_CYCLES, 3, clocks each yellow phase lasts (>=1).
- ALLRED_CYCLES, 2, clocks of all-red clearance after each yellow (>=1).
- FLASH_CYCLES, 4, clocks per on/off half-period in flash mode (>=1).
- DIR_W (localparam), $clog2(NUM_DIR), width of the direction index.
- CNT_W (localparam), $clog2(max of the four durations)+1, width of the phase timer.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_DIR  per-approach demand; bit d=1 means approach d wants green. Level-sampled.
- flash  in  1  maintenance request; 1 = flashing-yellow mode.
- light  out  3*NUM_DIR  lamp groups; bits [3d+2:3d] = {R,G,Y} of approach d. Encodings: 100 red, 010 green, 001 yellow, 000 dark.
- active_dir  out  DIR_W  index of the approach currently owning green/yellow/clearance.
- phase  out  2  00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH.

Behaviour:
- Moore machine. light, active_dir and phase are decoded only from registered state, never from inputs.
- States: ALLRED, GREEN, YELLOW, FLASH. A phase timer holds each state for exactly its parameter count of cycles: it loads duration-1 on entry and transitions when it reads 0.
- Reset (reset=1 at posedge):
  - state=ALLRED, timer=ALLRED_CYCLES-1, active_dir=NUM_DIR-1.
  - All lamps 100; phase=00.
  - Reset overrides flash and any phase in progress.
- GREEN: lamp active_dir=010, all others 100. After GREEN_CYCLES, go to YELLOW.
- YELLOW: lamp active_dir=001, others 100. After YELLOW_CYCLES, go to ALLRED.
- ALLRED: all lamps 100. After ALLRED_CYCLES, go to GREEN with active_dir = next index.
- Next index: the first d, searching cyclically from active_dir+1 (mod NUM_DIR), with req[d]=1. req is sampled at the terminal ALLRED cycle.
  - If req==0, fall back to active_dir+1 mod NUM_DIR (fixed-time rotation).
  - If only the current approach requests, it is re-granted after clearance.
- Wrap-around: index NUM_DIR-1 -> 0. Handle non-power-of-two NUM_DIR explicitly.
- Only one approach is ever non-red. Green never follows green without yellow and all-red, except when entering FLASH.
- FLASH entry: flash=1 at any posedge outside reset; the next cycle state=FLASH, from any state, mid-phase.
  - All lamps alternate 001 for FLASH_CYCLES and 000 for FLASH_CYCLES, starting with 001.
  - active_dir is held.
- FLASH exit: the first posedge with flash=0 moves to ALLRED with a full ALLRED_CYCLES count and active_dir=NUM_DIR-1. The normal rotation restarts at the first requesting index from 0.
- Simultaneous events, in priority order: reset > flash > timer expiry. req changes mid-phase have no effect until the next ALLRED terminal cycle.
- Timer width is CNT_W; no overflow is possible by construction.

Decomposition:
- Shared package sig_pkg:
  - lamp encodings LAMP_RED=3'b100, LAMP_GRN=3'b010, LAMP_YEL=3'b001, LAMP_OFF=3'b000;
  - phase encodings PH_ALLRED/PH_GREEN/PH_YELLOW/PH_FLASH.
- One sub-module, phase_timer: loadable down-counter with a load value, load strobe and a zero flag. Parameterised by CNT_W. Used for both phase timing and the flash half-period.
- The next-direction round-robin search stays inline as a combinational function.

Test Plan:
- Reset, req=4'b1111, flash=0, defaults:
  - 2 cycles all-100; then dir0 010 for 8, 001 for 3, 100 for 2; then dir1 green.
  - Full rotation is 52 cycles; dir0 green again at cycle 54.
- req=4'b0100 held: after the initial clearance only dir2 cycles. active_dir stays 2, with green every 13 cycles.
- req=4'b0000: fixed rotation 0,1,2,3,0. Dropping req[1] mid-green of dir0 does not alter the current phase.
- flash=1 asserted during dir1 green:
  - next cycle, all lamps 001 for 4 cycles, then 000 for 4 cycles, repeating.
  - Deassert: 2 cycles all-red, then the first requester from 0 gets green.
- reset=1 asserted mid-yellow and during FLASH: next cycle all lamps 100, phase=00, active_dir=3. Sequence then matches scenario 1.
- NUM_DIR=3, GREEN_CYCLES=1: the index wraps 2->0 correctly; single-cycle green is observed; no two approaches are ever non-red simultaneously (assertion checked every cycle).
